mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width of all data ports.
REQ-003 Parameter MEM_LAT, default 2: read latency in cycles from the memory sampling edge to valid m_rdata; legal range 1..15.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 c_req, c_we  in  1 each  core request and write flag; held high until c_done.
REQ-007 c_addr, c_wdata  in  ADDR_W, DATA_W  core address and write data; held stable while c_req is high.
REQ-008 c_gnt, c_done  out  1 each  core grant pulse and completion pulse.
REQ-009 c_rdata  out  DATA_W  core read data.
REQ-010 d_req, d_we, d_addr, d_wdata, d_gnt, d_done, d_rdata: second-requester (DMA/loader) port; same widths and rules as the c_* port.
REQ-011 m_en, m_we  out  1 each  memory enable and write strobe.
REQ-012 m_addr, m_wdata  out  ADDR_W, DATA_W  memory address and write data.
REQ-013 m_rdata  in  DATA_W  memory read data.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS, WAIT and DONE.
REQ-016 IDLE: if any request is high, the FSM SHALL latch the winner's we/addr/wdata and owner ID and go to ACCESS; otherwise it SHALL remain in IDLE.
REQ-017 ACCESS (exactly 1 cycle): m_en=1, m_we=latched we, m_addr/m_wdata=latched values, and the owner's gnt=1; next state is DONE for a write and WAIT for a read.
REQ-018 WAIT: a down-counter loaded with MEM_LAT SHALL decrement each cycle; in the cycle it reads 1, m_rdata SHALL be captured into the owner's rdata register and the next state is DONE.
REQ-019 DONE (exactly 1 cycle): the owner's done=1, then the next state is IDLE.
REQ-020 Latency from IDLE sampling a request: write = 2 cycles to done; read = MEM_LAT+2 cycles to done.
REQ-021 m_en, m_we and gnt SHALL be 0 outside ACCESS; done SHALL be 0 outside DONE; the non-owner's gnt/done SHALL never assert.
REQ-022 c_rdata/d_rdata SHALL hold their values until that port's next read completes; writes SHALL NOT alter them.
REQ-023 A requester SHALL deassert req in the cycle after its done pulse; a req still high in the following IDLE cycle is a new request.
REQ-024 Deasserting req after acceptance SHALL NOT abort the transaction; it completes with its done pulse.
REQ-025 With a single request pending, that request SHALL win. With both pending, the winner SHALL follow REQ-030/031.
REQ-026 The last_owner register SHALL update only on acceptance in IDLE.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, counter=0 and last_owner=DMA; all gnt/done/m_en/m_we/busy SHALL be 0 and both rdata registers and m_addr/m_wdata SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no done pulse and no rdata update.
REQ-029 The first edge after rst deasserts SHALL evaluate requests in IDLE.

Configuration
REQ-030 Without MEMARB_FIXED_PRIO_EN (default): on simultaneous requests, the port that is not last_owner SHALL win (round-robin).
REQ-031 With MEMARB_FIXED_PRIO_EN defined: the core SHALL always win simultaneous requests, last_owner SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Core read addr 0x40 with m_rdata=0xDEADBEEF, MEM_LAT=2 -> c_gnt 1 cycle after req; c_done 4 cycles after req; c_rdata=0xDEADBEEF; d_* quiet.
REQ-033 DMA write addr 0x100 data 0x12345678 -> exactly one cycle with m_en=1, m_we=1, m_addr=0x100, m_wdata=0x12345678; d_done 2 cycles after req.
REQ-034 c_req and d_req held continuously, round-robin build -> grants after reset: C, D, C, D; fixed-priority build -> C, C, C with DMA starved.
REQ-035 rst pulsed in the WAIT cycle of a core read -> busy=0 immediately, no c_done, c_rdata=0; the next request is served normally.
REQ-036 c_req dropped the cycle after c_gnt on a read -> transaction completes; c_done pulses; exactly one m_en pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (core / DMA) single-memory arbiter with a fixed-latency read wait.
// Define MEMARB_FIXED_PRIO_EN for core-first priority; default is round-robin.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {OWN_CORE, OWN_DMA} owner_t;

    state_t            state, next_state;
    owner_t            owner, last_owner, win;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] c_rdata_q, d_rdata_q;

    // Winner among simultaneous requests
    always_comb begin
        win = OWN_CORE;
        if (c_req && d_req) begin
`ifdef MEMARB_FIXED_PRIO_EN
            win = OWN_CORE;
`else
            win = (last_owner == OWN_DMA) ? OWN_CORE : OWN_DMA;
`endif
        end else if (d_req) begin
            win = OWN_DMA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (c_req || d_req) next_state = ACCESS;
            ACCESS:  next_state = lat_we ? DONE : WAIT;
            WAIT:    if (cnt == 4'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            owner      <= OWN_CORE;
            last_owner <= OWN_DMA;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_req || d_req) begin
                        owner      <= win;
                        last_owner <= win;
                        if (win == OWN_DMA) begin
                            lat_we    <= d_we;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                        end else begin
                            lat_we    <= c_we;
                            lat_addr  <= c_addr;
                            lat_wdata <= c_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!lat_we) cnt <= 4'(MEM_LAT);
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Memory data is valid in the last wait cycle
                    if (cnt == 4'd1) begin
                        if (owner == OWN_DMA) d_rdata_q <= m_rdata;
                        else                  c_rdata_q <= m_rdata;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        m_en   = 1'b0;
        m_we   = 1'b0;
        c_gnt  = 1'b0;
        d_gnt  = 1'b0;
        c_done = 1'b0;
        d_done = 1'b0;
        case (state)
            ACCESS: begin
                m_en = 1'b1;
                m_we = lat_we;
                if (owner == OWN_DMA) d_gnt = 1'b1;
                else                  c_gnt = 1'b1;
            end
            DONE: begin
                if (owner == OWN_DMA) d_done = 1'b1;
                else                  c_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transfers queue expected done
// pulses; a negedge monitor pops and checks port, timing and read data.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_done, d_gnt, d_done;
    logic [31:0] c_rdata, d_rdata;
    logic        m_en, m_we, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: read data appears LAT edges after the sampling edge, garbage otherwise
    logic [31:0]    mem [0:1023];
    logic [LAT-1:0] pv = '0;
    logic [31:0]    pd [LAT];
    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr[11:2]] <= m_wdata;
        pv[0] <= m_en && !m_we;
        pd[0] <= mem[m_addr[11:2]];
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign m_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;

    typedef struct {
        logic        dma;
        logic        we;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic dma, input logic we, input logic [31:0] rd, input int dc);
        exp_t e;
        e.dma = dma; e.we = we; e.rdata = rd; e.done_cyc = dc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (c_done || d_done) begin
            if (c_done && d_done) begin
                check("done_exclusive", {c_done, d_done}, 2'b01);
            end else if (sb.size() == 0) begin
                check("unexpected_done", {c_done, d_done}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_port", d_done, e.dma);
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                if (!e.we) check("rdata", d_done ? d_rdata : c_rdata, e.rdata);
            end
        end
    end

    task automatic set_req(input logic dma, input logic v);
        if (dma) d_req = v;
        else     c_req = v;
    endtask

    task automatic xfer(input logic dma, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input int exp_lat, input bit drop_early, input string name);
        int  npulse;
        bit  seen;
        @(negedge clk);
        if (dma) begin d_we = we; d_addr = addr; d_wdata = wdata; end
        else     begin c_we = we; c_addr = addr; c_wdata = wdata; end
        set_req(dma, 1'b1);
        push(dma, we, exp_rd, cyc + exp_lat);
        @(negedge clk);
        check({name, "_gnt"}, dma ? d_gnt : c_gnt, 1);
        check({name, "_other_gnt"}, dma ? c_gnt : d_gnt, 0);
        check({name, "_m_we"}, {m_en, m_we}, {1'b1, we});
        check({name, "_m_addr"}, m_addr, addr);
        if (we) check({name, "_m_wdata"}, m_wdata, wdata);
        npulse = int'(m_en);
        if (drop_early) set_req(dma, 1'b0);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            npulse += int'(m_en);
            if (dma ? d_done : c_done) seen = 1;
        end
        set_req(dma, 1'b0);
        check({name, "_done_seen"}, seen, 1);
        check({name, "_m_en_pulses"}, npulse, 1);
    endtask

    logic seq [4];
    logic gn  [8];
    int   ng;
    int   n0;
    int   ndone;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        mem[32'h80 >> 2] = 32'hCAFE_F00D;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_gnt", {c_gnt, d_gnt}, 0);
        check("rst_done", {c_done, d_done}, 0);
        check("rst_m_en_we", {m_en, m_we}, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_rdata", {c_rdata, d_rdata}, 0);
        rst = 1'b0;

        xfer(0, 0, 32'h40, 0, 32'hDEAD_BEEF, 4, 0, "core_rd40");
        check("d_rdata_quiet", d_rdata, 0);
        xfer(1, 1, 32'h100, 32'h1234_5678, 0, 2, 0, "dma_wr100");
        check("wr_keeps_c_rdata", c_rdata, 32'hDEAD_BEEF);
        check("wr_keeps_d_rdata", d_rdata, 0);
        xfer(1, 0, 32'h100, 0, 32'h1234_5678, 4, 0, "dma_rd100");
        check("d_rd_keeps_c_rdata", c_rdata, 32'hDEAD_BEEF);
        xfer(0, 0, 32'h80, 0, 32'hCAFE_F00D, 4, 1, "core_rd80_drop");

        // Reset during the WAIT cycle of a core read
        @(negedge clk);
        c_we = 0; c_addr = 32'h40; c_req = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        c_req = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_c_rdata", c_rdata, 0);
        check("midrst_d_rdata", d_rdata, 0);
        check("midrst_m_en", m_en, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            ndone += int'(c_done);
        end
        check("midrst_no_done", ndone, 0);
        xfer(0, 0, 32'h40, 0, 32'hDEAD_BEEF, 4, 0, "core_rd40_after_rst");

        // Both requesters held continuously after a fresh reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef MEMARB_FIXED_PRIO_EN
        seq = '{0, 0, 0, 0};
`else
        seq = '{0, 1, 0, 1};
`endif
        @(negedge clk);
        c_we = 1; c_addr = 32'h200; c_wdata = 32'hA1A1_0001;
        d_we = 1; d_addr = 32'h300; d_wdata = 32'hB2B2_0002;
        c_req = 1; d_req = 1;
        n0 = cyc;
        for (int i = 0; i < 4; i++) push(seq[i], 1'b1, 32'h0, n0 + 2 + 3 * i);
        ng = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if ((c_gnt || d_gnt) && ng < 8) begin
                gn[ng] = d_gnt;
                check("rr_m_addr", m_addr, d_gnt ? 32'h300 : 32'h200);
                ng++;
            end
            if (k == 11) begin
                c_req = 0;
                d_req = 0;
            end
        end
        check("rr_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), gn[i], seq[i]);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
